// File: rtl/dhm_stream_pkg.sv
// Shared widths and elaboration helpers for the dhm stream width converters.
package dhm_stream_pkg;

  localparam int DHM_BYTE_W = 8;
  localparam int DHM_BLK_W  = 64;

  function automatic int f_lanes(input int w, input int nw);
    return w / nw;
  endfunction

  function automatic int f_ratio(input int a, input int b);
    return (a > b) ? a / b : b / a;
  endfunction

  function automatic bit f_pow2(input int w);
    return (w > 0) && ((w & (w - 1)) == 0);
  endfunction

  localparam int DHM_IDX_W = $clog2(f_ratio(DHM_BLK_W, DHM_BYTE_W));
  typedef logic [DHM_IDX_W-1:0] dhm_lane_t;

endpackage

// File: rtl/dhm_stream_reg.sv
// One-entry valid/ready register slice carrying data, keep and last.
module dhm_stream_reg
#(
  parameter int DW = 8,
  parameter int KW = 1
)(
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] d_i,
  input  logic [KW-1:0] k_i,
  input  logic          l_i,
  input  logic          v_i,
  output logic          r_o,
  output logic [DW-1:0] d_o,
  output logic [KW-1:0] k_o,
  output logic          l_o,
  output logic          v_o,
  input  logic          r_i
);

  logic          vld_q;
  logic [DW-1:0] data_q;
  logic [KW-1:0] keep_q;
  logic          last_q;

  // Full-throughput slice: a new entry may load in the cycle the old one drains.
  assign r_o = !vld_q || r_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
    end else if (v_i && r_o) begin
      vld_q  <= 1'b1;
      data_q <= d_i;
      keep_q <= k_i;
      last_q <= l_i;
    end else if (r_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign v_o = vld_q;
  assign d_o = data_q;
  assign k_o = keep_q;
  assign l_o = last_q;

endmodule

// File: rtl/dhm_stream_gearbox.sv
// Valid/ready width converter: packs or unpacks LSB-first lanes, or acts as a register slice.
module dhm_stream_gearbox
  import dhm_stream_pkg::*;
#(
  parameter  int IN_W  = DHM_BYTE_W,
  parameter  int OUT_W = DHM_BLK_W,
  localparam int NW    = (IN_W < OUT_W) ? IN_W : OUT_W,
  localparam int IKW   = f_lanes(IN_W, NW),
  localparam int OKW   = f_lanes(OUT_W, NW)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  i_data,
  input  logic [IKW-1:0]   i_keep,
  input  logic             i_last,
  input  logic             i_rval,
  output logic             o_rrdy,
  output logic [OUT_W-1:0] o_data,
  output logic [OKW-1:0]   o_keep,
  output logic             o_last,
  output logic             o_tval,
  input  logic             i_trdy,
  output logic             o_busy
);

  localparam int RATIO = f_ratio(IN_W, OUT_W);

  if (!(f_pow2(IN_W) && f_pow2(OUT_W))) begin : g_bad_width
    $error("dhm_stream_gearbox: IN_W and OUT_W must be powers of two");
  end

  logic rdy_c;
  assign o_rrdy = rdy_c && !reset;

  if (IN_W < OUT_W) begin : g_pack
    localparam int IW = $clog2(RATIO);
    logic [IW-1:0]    idx_q, idx_d;
    logic [OUT_W-1:0] acc_q, acc_d, merged;
    logic [OKW-1:0]   keep_c;
    logic             done;
    logic             unused_keep;

    assign unused_keep = ^i_keep;

    always_comb begin
      merged = acc_q;
      keep_c = '0;
      for (int j = 0; j < RATIO; j++) begin
        if (int'(idx_q) == j) merged[j*NW +: NW] = i_data;
        if (j <= int'(idx_q)) keep_c[j] = 1'b1;
      end
    end

    assign done = (idx_q == IW'(RATIO - 1)) || i_last;

    // Completed words bypass the accumulator straight into the output slice.
    always_comb begin
      idx_d = idx_q;
      acc_d = acc_q;
      if (i_rval && o_rrdy) begin
        if (done) begin
          idx_d = '0;
          acc_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
          acc_d = merged;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        idx_q <= '0;
        acc_q <= '0;
      end else begin
        idx_q <= idx_d;
        acc_q <= acc_d;
      end
    end

    dhm_stream_reg #(.DW(OUT_W), .KW(OKW)) u_out (
      .clk(clk), .reset(reset),
      .d_i(merged), .k_i(keep_c), .l_i(i_last), .v_i(i_rval && done), .r_o(rdy_c),
      .d_o(o_data), .k_o(o_keep), .l_o(o_last), .v_o(o_tval), .r_i(i_trdy)
    );

    assign o_busy = !reset && (idx_q != '0);

  end else if (IN_W > OUT_W) begin : g_unpack
    localparam int IW = $clog2(RATIO);
    logic [IW-1:0]   lane_q, kmax;
    logic [IN_W-1:0] h_data;
    logic [IKW-1:0]  h_keep;
    logic            h_last, h_val, last_lane;

    // The slice holds the wide word; it drains when its final lane is taken.
    dhm_stream_reg #(.DW(IN_W), .KW(IKW)) u_hold (
      .clk(clk), .reset(reset),
      .d_i(i_data), .k_i(i_keep), .l_i(i_last), .v_i(i_rval), .r_o(rdy_c),
      .d_o(h_data), .k_o(h_keep), .l_o(h_last), .v_o(h_val), .r_i(i_trdy && last_lane)
    );

    always_comb begin
      kmax   = '0;
      o_data = '0;
      for (int j = 0; j < RATIO; j++) begin
        if (h_keep[j]) kmax = IW'(j);
        if (int'(lane_q) == j) o_data = h_data[j*NW +: NW];
      end
    end

    assign last_lane = (lane_q == kmax);

    always_ff @(posedge clk) begin
      if (reset)               lane_q <= '0;
      else if (h_val && i_trdy) lane_q <= last_lane ? '0 : lane_q + 1'b1;
    end

    assign o_tval = h_val;
    assign o_keep = h_val;
    assign o_last = h_val && h_last && last_lane;
    assign o_busy = h_val;

  end else begin : g_equal
    dhm_stream_reg #(.DW(IN_W), .KW(IKW)) u_out (
      .clk(clk), .reset(reset),
      .d_i(i_data), .k_i(i_keep), .l_i(i_last), .v_i(i_rval), .r_o(rdy_c),
      .d_o(o_data), .k_o(o_keep), .l_o(o_last), .v_o(o_tval), .r_i(i_trdy)
    );
    assign o_busy = o_tval;
  end

endmodule
